kernel_sort_seq: RTL and testbench



---
 rtl/kernel_sort_seq.sv | 157 +++++++++++++++
 tb/tb_kernel_sort_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_sort_seq.sv
// kernel_sort_seq: sequential odd-even transposition sorter for sign-magnitude
// Gabor kernel coefficients. It orders entries by ascending magnitude (ignoring the
// sign), keeps ties in their original order, and returns each entry's original index.
// Optional feature macro: KSORT_NZCOUNT_EN adds the nz_count output.
module kernel_sort_seq #(
  parameter int unsigned KERNEL_SIZE = 11,
  parameter int unsigned NUM_VALS    = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_VALS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [KERNEL_SIZE-1:0] kernel   [0:NUM_VALS-1],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [KERNEL_SIZE-1:0] sort_out [0:NUM_VALS-1],
  output logic [IDX_W-1:0]       sel      [0:NUM_VALS-1],
  output logic                   busy
`ifdef KSORT_NZCOUNT_EN
  ,
  output logic [$clog2(NUM_VALS+1)-1:0] nz_count
`endif
);

  localparam int unsigned PH_W  = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam int unsigned MAG_W = KERNEL_SIZE - 1;

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [KERNEL_SIZE-1:0] work_q [0:NUM_VALS-1];
  logic [KERNEL_SIZE-1:0] work_d [0:NUM_VALS-1];
  logic [IDX_W-1:0]       tag_q  [0:NUM_VALS-1];
  logic [IDX_W-1:0]       tag_d  [0:NUM_VALS-1];
  logic                   capture;
  logic                   last_phase;

  assign capture    = (state_q == StIdle) && in_valid;
  assign last_phase = (phase_q == PH_W'(NUM_VALS - 1));

  // Control FSM: next state, phase counter and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StSort;
          phase_d = '0;
        end
      end
      StSort: begin
        busy    = 1'b1;
        phase_d = phase_q + PH_W'(1);
        if (last_phase) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Working registers: load on capture, then one compare-exchange phase per cycle.
  // Pairs within a phase are disjoint, so every pair reads the registered values.
  always_comb begin
    work_d = work_q;
    tag_d  = tag_q;
    if (capture) begin
      for (int i = 0; i < int'(NUM_VALS); i++) begin
        work_d[i] = kernel[i];
        tag_d[i]  = IDX_W'(i);
      end
    end else if (state_q == StSort) begin
      for (int i = 0; i < int'(NUM_VALS) - 1; i++) begin
        // Strict compare keeps equal magnitudes in place, which makes the sort stable.
        if (((i % 2) == int'(phase_q[0])) &&
            (work_q[i][MAG_W-1:0] > work_q[i+1][MAG_W-1:0])) begin
          work_d[i]   = work_q[i+1];
          work_d[i+1] = work_q[i];
          tag_d[i]    = tag_q[i+1];
          tag_d[i+1]  = tag_q[i];
        end
      end
    end
  end

  // Working register storage; tags reset to the identity permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VALS); i++) begin
        work_q[i] <= '0;
        tag_q[i]  <= IDX_W'(i);
      end
    end else begin
      work_q <= work_d;
      tag_q  <= tag_d;
    end
  end

  assign sort_out = work_q;
  assign sel      = tag_q;

`ifdef KSORT_NZCOUNT_EN
  localparam int unsigned NZ_W = $clog2(NUM_VALS + 1);

  logic [NZ_W-1:0] nz_q, nz_d;

  // Count nonzero input magnitudes; the count is only latched on the capture edge.
  always_comb begin
    nz_d = nz_q;
    if (capture) begin
      nz_d = '0;
      for (int i = 0; i < int'(NUM_VALS); i++) begin
        if (kernel[i][MAG_W-1:0] != '0) begin
          nz_d = nz_d + NZ_W'(1);
        end
      end
    end
  end

  // Nonzero count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q <= '0;
    end else begin
      nz_q <= nz_d;
    end
  end

  assign nz_count = nz_q;
`endif

endmodule

// File: tb/tb_kernel_sort_seq.sv
// Self-checking bench for kernel_sort_seq with NUM_VALS=4 and NUM_VALS=8 instances.
// Expected results come from a stable rank-by-magnitude reference model.
module tb_kernel_sort_seq;

  localparam int KS = 11;

  logic clk;
  logic rst;

  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [KS-1:0] kernel   [0:3];
  logic [KS-1:0] sort_out [0:3];
  logic [1:0]    sel      [0:3];

  logic          in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [KS-1:0] kernel8   [0:7];
  logic [KS-1:0] sort_out8 [0:7];
  logic [2:0]    sel8      [0:7];

`ifdef KSORT_NZCOUNT_EN
  logic [2:0] nz_count;
  logic [3:0] nz_count8;
`endif

  int errors = 0;
  int checks = 0;

  kernel_sort_seq #(.KERNEL_SIZE(KS), .NUM_VALS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .kernel    (kernel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sort_out  (sort_out),
    .sel       (sel),
    .busy      (busy)
`ifdef KSORT_NZCOUNT_EN
    ,
    .nz_count  (nz_count)
`endif
  );

  kernel_sort_seq #(.KERNEL_SIZE(KS), .NUM_VALS(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .kernel    (kernel8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sort_out  (sort_out8),
    .sel       (sel8),
    .busy      (busy8)
`ifdef KSORT_NZCOUNT_EN
    ,
    .nz_count  (nz_count8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stable sort by magnitude: an entry's rank is the number of entries with smaller
  // magnitude plus equal-magnitude entries with a lower original index.
  task automatic ref_sort(input int n, input logic [7:0][KS-1:0] v,
                          output logic [7:0][KS-1:0] so, output logic [7:0][2:0] si,
                          output int nz);
    so = '0;
    si = '0;
    nz = 0;
    for (int i = 0; i < n; i++) begin
      int pos = 0;
      for (int j = 0; j < n; j++) begin
        if (v[j][KS-2:0] < v[i][KS-2:0] || (v[j][KS-2:0] == v[i][KS-2:0] && j < i)) pos++;
      end
      so[pos] = v[i];
      si[pos] = 3'(i);
      if (v[i][KS-2:0] != 0) nz++;
    end
  endtask

  function automatic logic [7:0][KS-1:0] rand_vec(input int n, input int maxmag);
    logic [7:0][KS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = {1'($urandom), 10'($urandom_range(0, maxmag))};
    return v;
  endfunction

  task automatic drive4(input logic [7:0][KS-1:0] v);
    for (int i = 0; i < 4; i++) kernel[i] = v[i];
  endtask

  // Present a vector for one capture edge and count cycles until out_valid (bounded).
  task automatic send4(input logic [7:0][KS-1:0] v, output int lat);
    drive4(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send8(input logic [7:0][KS-1:0] v, output int lat);
    for (int i = 0; i < 8; i++) kernel8[i] = v[i];
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack4();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic ack8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    for (int i = 0; i < 4; i++) kernel[i] = '0;
    for (int i = 0; i < 8; i++) kernel8[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== 11'h000) begin errors++; $display("FAIL reset_sort_out[%0d]: got %h want 000", i, sort_out[i]); end
      checks++; if (sel[i] !== 2'(i)) begin errors++; $display("FAIL reset_sel[%0d]: got %0d want %0d", i, sel[i], i); end
    end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b want 1", in_ready8); end
`ifdef KSORT_NZCOUNT_EN
    checks++; if (nz_count !== 3'd0) begin errors++; $display("FAIL reset_nz: got %0d want 0", nz_count); end
`endif
  endtask

  task automatic test_fixed_vectors();
    logic [7:0][KS-1:0] v;
    logic [3:0][KS-1:0] exp_so;
    logic [3:0][1:0]    exp_sel;
    int lat;
    // Base vector.
    v = '0;
    v[0] = 11'h0E8; v[1] = 11'h407; v[2] = 11'h4FE; v[3] = 11'h000;
    exp_so  = {11'h4FE, 11'h0E8, 11'h407, 11'h000};
    exp_sel = {2'd2, 2'd0, 2'd1, 2'd3};
    send4(v, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL base_latency: got %0d want 4", lat); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL base_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== exp_so[i]) begin errors++; $display("FAIL base_sort_out[%0d]: got %h want %h", i, sort_out[i], exp_so[i]); end
      checks++; if (sel[i] !== exp_sel[i]) begin errors++; $display("FAIL base_sel[%0d]: got %0d want %0d", i, sel[i], exp_sel[i]); end
    end
`ifdef KSORT_NZCOUNT_EN
    checks++; if (nz_count !== 3'd3) begin errors++; $display("FAIL base_nz: got %0d want 3", nz_count); end
`endif
    ack4();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL base_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    // Ties keep original order.
    v = '0;
    v[0] = 11'h005; v[1] = 11'h405; v[2] = 11'h003; v[3] = 11'h005;
    exp_so  = {11'h005, 11'h405, 11'h005, 11'h003};
    exp_sel = {2'd3, 2'd1, 2'd0, 2'd2};
    send4(v, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL ties_latency: got %0d want 4", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== exp_so[i]) begin errors++; $display("FAIL ties_sort_out[%0d]: got %h want %h", i, sort_out[i], exp_so[i]); end
      checks++; if (sel[i] !== exp_sel[i]) begin errors++; $display("FAIL ties_sel[%0d]: got %0d want %0d", i, sel[i], exp_sel[i]); end
    end
    ack4();
  endtask

  task automatic test_random();
    logic [7:0][KS-1:0] v, so;
    logic [7:0][2:0]    si;
    int nz, lat;
    for (int t = 0; t < 12; t++) begin
      v = rand_vec(4, (t % 2 == 0) ? 3 : 1023);
      ref_sort(4, v, so, si, nz);
      send4(v, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL rand_latency t=%0d: got %0d want 4", t, lat); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (sort_out[i] !== so[i]) begin errors++; $display("FAIL rand_sort_out t=%0d [%0d]: got %h want %h", t, i, sort_out[i], so[i]); end
        checks++; if (sel[i] !== si[i][1:0]) begin errors++; $display("FAIL rand_sel t=%0d [%0d]: got %0d want %0d", t, i, sel[i], si[i][1:0]); end
      end
`ifdef KSORT_NZCOUNT_EN
      checks++; if (nz_count !== 3'(nz)) begin errors++; $display("FAIL rand_nz t=%0d: got %0d want %0d", t, nz_count, nz); end
`endif
      ack4();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0][KS-1:0] v, so;
    logic [7:0][2:0]    si;
    int nz, lat;
    v = rand_vec(4, 1023);
    ref_sort(4, v, so, si, nz);
    send4(v, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold c=%0d: got out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (sort_out[i] !== so[i] || sel[i] !== si[i][1:0]) begin errors++; $display("FAIL bp_stable c=%0d [%0d]: got %h/%0d want %h/%0d", c, i, sort_out[i], sel[i], so[i], si[i][1:0]); end
      end
      if (c == 3) begin
        drive4(rand_vec(4, 1023));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    ack4();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_capture: got busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== so[i]) begin errors++; $display("FAIL bp_idle_hold[%0d]: got %h want %h", i, sort_out[i], so[i]); end
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [7:0][KS-1:0] v, so;
    logic [7:0][2:0]    si;
    int nz, lat, ov_seen;
    drive4(rand_vec(4, 1023));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ctrl: got ov=%b busy=%b ir=%b want 0/0/1", out_valid, busy, in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== 11'h000 || sel[i] !== 2'(i)) begin errors++; $display("FAIL midrst_regs[%0d]: got %h/%0d want 000/%0d", i, sort_out[i], sel[i], i); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ov_seen++;
    end
    checks++; if (ov_seen != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d pulses want 0", ov_seen); end
    v = rand_vec(4, 1023);
    ref_sort(4, v, so, si, nz);
    send4(v, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL midrst_next_latency: got %0d want 4", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sort_out[i] !== so[i] || sel[i] !== si[i][1:0]) begin errors++; $display("FAIL midrst_next[%0d]: got %h/%0d want %h/%0d", i, sort_out[i], sel[i], so[i], si[i][1:0]); end
    end
    ack4();
  endtask

  task automatic test_n8();
    logic [7:0][KS-1:0] v, so;
    logic [7:0][2:0]    si;
    int nz, lat;
    for (int i = 0; i < 8; i++) v[i] = {1'($urandom), 10'(7 - i)};
    send8(v, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL n8_rev_latency: got %0d want 8", lat); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (sel8[i] !== 3'(7 - i)) begin errors++; $display("FAIL n8_rev_sel[%0d]: got %0d want %0d", i, sel8[i], 7 - i); end
      checks++; if (sort_out8[i] !== v[7 - i]) begin errors++; $display("FAIL n8_rev_sort_out[%0d]: got %h want %h", i, sort_out8[i], v[7 - i]); end
    end
`ifdef KSORT_NZCOUNT_EN
    checks++; if (nz_count8 !== 4'd7) begin errors++; $display("FAIL n8_rev_nz: got %0d want 7", nz_count8); end
`endif
    ack8();
    for (int t = 0; t < 4; t++) begin
      v = rand_vec(8, (t % 2 == 0) ? 5 : 1023);
      ref_sort(8, v, so, si, nz);
      send8(v, lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL n8_rand_latency t=%0d: got %0d want 8", t, lat); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (sort_out8[i] !== so[i] || sel8[i] !== si[i]) begin errors++; $display("FAIL n8_rand t=%0d [%0d]: got %h/%0d want %h/%0d", t, i, sort_out8[i], sel8[i], so[i], si[i]); end
      end
`ifdef KSORT_NZCOUNT_EN
      checks++; if (nz_count8 !== 4'(nz)) begin errors++; $display("FAIL n8_rand_nz t=%0d: got %0d want %0d", t, nz_count8, nz); end
`endif
      ack8();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0][KS-1:0] cur, exp_v, so;
    logic [7:0][KS-1:0] q[$];
    logic [7:0][2:0]    si;
    logic rdy_prev;
    int nz, caps, res, last_ov, cyc;
    caps = 0; res = 0; last_ov = -1; cyc = 0;
    cur = rand_vec(4, 15);
    drive4(cur);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rdy_prev  = in_ready;
    while (res < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy_prev && in_valid) begin
        q.push_back(cur);
        caps++;
        if (caps < 5) begin
          cur = rand_vec(4, 15);
          drive4(cur);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got result with no capture, want none");
        end else begin
          exp_v = q.pop_front();
          ref_sort(4, exp_v, so, si, nz);
          for (int i = 0; i < 4; i++) begin
            if (sort_out[i] !== so[i] || sel[i] !== si[i][1:0]) begin
              errors++; $display("FAIL b2b_result r=%0d [%0d]: got %h/%0d want %h/%0d", res, i, sort_out[i], sel[i], so[i], si[i][1:0]);
              break;
            end
          end
        end
        if (last_ov >= 0) begin
          checks++; if (cyc - last_ov != 6) begin errors++; $display("FAIL b2b_period r=%0d: got %0d want 6", res, cyc - last_ov); end
        end
        last_ov = cyc;
        res++;
      end
      rdy_prev = in_ready;
    end
    in_valid = 1'b0;
    checks++; if (res != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", res); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_sort();
    test_n8();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
